// File: rtl/fht_but_seq.sv
// rtl/fht_but_seq.sv - radix-2 FHT butterfly address sequencer with ping-pong banks
module fht_but_seq #(
    parameter int A_BIT   = 8,
    parameter int RD_LAT  = 1,
    parameter int BUT_LAT = 2,
    localparam int SW     = $clog2(A_BIT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [A_BIT-1:0] rd_addr_0,
    output logic [A_BIT-1:0] rd_addr_1,
    output logic [A_BIT-1:0] rd_addr_2,
    output logic [A_BIT-2:0] rom_addr,
    output logic             rd_bank,
    output logic             wr_en,
    output logic [A_BIT-1:0] wr_addr_0,
    output logic [A_BIT-1:0] wr_addr_1,
    output logic [SW-1:0]    stage,
    output logic             res_bank
);

    localparam int D  = RD_LAT + BUT_LAT;
    localparam int CW = $clog2(D) + 1;
    localparam int PW = 1 + 2 * A_BIT;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_FIN} state_t;

    state_t           state;
    state_t           state_nx;
    logic [A_BIT-2:0] bfly;
    logic [SW-1:0]    stg;
    logic [CW-1:0]    fcnt;
    logic             last_bfly;
    logic             last_flush;
    logic             last_stage;

    logic [A_BIT-2:0] kmask;
    logic [A_BIT-2:0] k;
    logic [A_BIT-2:0] j;
    logic [A_BIT-1:0] h;
    logic [A_BIT-1:0] g;
    logic [A_BIT-1:0] x0;
    logic [A_BIT-1:0] x1;
    logic [A_BIT-1:0] x2;

    // Each entry carries {rd_en, x0, x1} toward the write-back side
    logic [PW-1:0]    pipe [D];

    assign last_bfly  = &bfly;
    assign last_flush = (fcnt == CW'(D - 1));
    assign last_stage = (stg == SW'(A_BIT - 1));

    // State register; reset aborts any transform in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: start is honoured only from IDLE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (last_bfly) state_nx = S_FLUSH;
            S_FLUSH: if (last_flush) state_nx = last_stage ? S_FIN : S_RUN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Butterfly, flush and stage counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bfly <= '0;
            fcnt <= '0;
            stg  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    bfly <= bfly + (A_BIT-1)'(1);
                end
                S_FLUSH: begin
                    if (last_flush) begin
                        fcnt <= '0;
                        if (!last_stage) stg <= stg + SW'(1);
                    end else begin
                        fcnt <= fcnt + CW'(1);
                    end
                end
                S_FIN: begin
                    stg <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Operand and twiddle addresses: low stg bits of b are k, the rest select the group
    always_comb begin
        kmask = ~({(A_BIT-1){1'b1}} << stg);
        k     = bfly & kmask;
        h     = A_BIT'(1) << stg;
        g     = {bfly & ~kmask, 1'b0};
        x0    = g + {1'b0, k};
        x1    = x0 + h;
        x2    = g + h + ((h - {1'b0, k}) & {1'b0, kmask});
        j     = k << (SW'(A_BIT - 1) - stg);
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);
    assign rd_en     = (state == S_RUN);
    assign rd_addr_0 = rd_en ? x0 : '0;
    assign rd_addr_1 = rd_en ? x1 : '0;
    assign rd_addr_2 = rd_en ? x2 : '0;
    assign rom_addr  = rd_en ? j : '0;
    assign rd_bank   = stg[0];
    assign stage     = stg;
    assign res_bank  = 1'(A_BIT % 2);

    // Write-back delay line matching read plus butterfly latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {rd_en, rd_addr_0, rd_addr_1};
            for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {wr_en, wr_addr_0, wr_addr_1} = pipe[D-1];

endmodule

// File: tb/tb_fht_but_seq.sv
// tb/tb_fht_but_seq.sv - self-checking bench for fht_but_seq (A_BIT=3 and A_BIT=8)
module tb_fht_but_seq;

    localparam int D = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       s_start, s_busy, s_done, s_rd_en, s_rd_bank, s_wr_en, s_res_bank;
    logic [2:0] s_rd_addr_0, s_rd_addr_1, s_rd_addr_2, s_wr_addr_0, s_wr_addr_1, s_stage;
    logic [1:0] s_rom_addr;

    logic       b_start, b_busy, b_done, b_rd_en, b_rd_bank, b_wr_en, b_res_bank;
    logic [7:0] b_rd_addr_0, b_rd_addr_1, b_rd_addr_2, b_wr_addr_0, b_wr_addr_1;
    logic [6:0] b_rom_addr;
    logic [3:0] b_stage;

    int checks = 0;
    int errors = 0;

    fht_but_seq #(.A_BIT(3), .RD_LAT(1), .BUT_LAT(2)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .rd_en(s_rd_en), .rd_addr_0(s_rd_addr_0), .rd_addr_1(s_rd_addr_1),
        .rd_addr_2(s_rd_addr_2), .rom_addr(s_rom_addr), .rd_bank(s_rd_bank),
        .wr_en(s_wr_en), .wr_addr_0(s_wr_addr_0), .wr_addr_1(s_wr_addr_1),
        .stage(s_stage), .res_bank(s_res_bank)
    );

    fht_but_seq #(.A_BIT(8), .RD_LAT(1), .BUT_LAT(2)) dut_big (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rd_en(b_rd_en), .rd_addr_0(b_rd_addr_0), .rd_addr_1(b_rd_addr_1),
        .rd_addr_2(b_rd_addr_2), .rom_addr(b_rom_addr), .rd_bank(b_rd_bank),
        .wr_en(b_wr_en), .wr_addr_0(b_wr_addr_0), .wr_addr_1(b_wr_addr_1),
        .stage(b_stage), .res_bank(b_res_bank)
    );

    // Reference: sel 0=x0, 1=x1, 2=x2, 3=twiddle index j, from the stage/butterfly arithmetic
    function automatic int model(input int abit, input int s, input int b, input int sel);
        int n, l, h, g, k;
        n = 1 << abit;
        l = 1 << (s + 1);
        h = l / 2;
        g = (b / h) * l;
        k = b % h;
        case (sel)
            0:       return g + k;
            1:       return g + h + k;
            2:       return g + h + ((h - k) % h);
            default: return k * (n / l);
        endcase
    endfunction

    // One full A_BIT=3 transform checked every cycle; optional ignored start pulses
    task automatic run_small(input string tag, input int mid_start, input bit start_at_done);
        int p, total, s, r, wc, ws;
        bit exp_rd, exp_wr;
        int ex0, ex1, ex2, ej, ew0, ew1;
        p     = 4 + D;
        total = 3 * p;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int c = 0; c <= total; c++) begin
            if (c > 0) @(negedge clk);
            s      = (c < total) ? c / p : 2;
            r      = c % p;
            exp_rd = (c < total) && (r < 4);
            ex0 = exp_rd ? model(3, s, r, 0) : 0;
            ex1 = exp_rd ? model(3, s, r, 1) : 0;
            ex2 = exp_rd ? model(3, s, r, 2) : 0;
            ej  = exp_rd ? model(3, s, r, 3) : 0;
            wc     = c - D;
            exp_wr = (wc >= 0) && (wc < total) && ((wc % p) < 4);
            ws     = (wc >= 0) ? wc / p : 0;
            ew0 = exp_wr ? model(3, ws, wc % p, 0) : 0;
            ew1 = exp_wr ? model(3, ws, wc % p, 1) : 0;
            checks += 12;
            if (s_busy !== 1'b1) begin errors++; $display("FAIL %s c=%0d busy got %b exp 1", tag, c, s_busy); end
            if (s_done !== (c == total)) begin errors++; $display("FAIL %s c=%0d done got %b exp %0d", tag, c, s_done, c == total); end
            if (s_rd_en !== exp_rd) begin errors++; $display("FAIL %s c=%0d rd_en got %b exp %0d", tag, c, s_rd_en, exp_rd); end
            if (s_rd_addr_0 !== 3'(ex0)) begin errors++; $display("FAIL %s c=%0d rd_addr_0 got %0d exp %0d", tag, c, s_rd_addr_0, ex0); end
            if (s_rd_addr_1 !== 3'(ex1)) begin errors++; $display("FAIL %s c=%0d rd_addr_1 got %0d exp %0d", tag, c, s_rd_addr_1, ex1); end
            if (s_rd_addr_2 !== 3'(ex2)) begin errors++; $display("FAIL %s c=%0d rd_addr_2 got %0d exp %0d", tag, c, s_rd_addr_2, ex2); end
            if (s_rom_addr !== 2'(ej)) begin errors++; $display("FAIL %s c=%0d rom_addr got %0d exp %0d", tag, c, s_rom_addr, ej); end
            if (s_rd_bank !== 1'(s % 2)) begin errors++; $display("FAIL %s c=%0d rd_bank got %b exp %0d", tag, c, s_rd_bank, s % 2); end
            if (s_stage !== 3'(s)) begin errors++; $display("FAIL %s c=%0d stage got %0d exp %0d", tag, c, s_stage, s); end
            if (s_wr_en !== exp_wr) begin errors++; $display("FAIL %s c=%0d wr_en got %b exp %0d", tag, c, s_wr_en, exp_wr); end
            if (s_wr_addr_0 !== 3'(ew0)) begin errors++; $display("FAIL %s c=%0d wr_addr_0 got %0d exp %0d", tag, c, s_wr_addr_0, ew0); end
            if (s_wr_addr_1 !== 3'(ew1)) begin errors++; $display("FAIL %s c=%0d wr_addr_1 got %0d exp %0d", tag, c, s_wr_addr_1, ew1); end
            s_start = (c == mid_start) || (start_at_done && c == total);
        end
        for (int c = total + 1; c <= total + 3; c++) begin
            @(negedge clk);
            s_start = 1'b0;
            checks += 3;
            if (s_busy !== 1'b0) begin errors++; $display("FAIL %s c=%0d idle busy got %b exp 0", tag, c, s_busy); end
            if (s_done !== 1'b0) begin errors++; $display("FAIL %s c=%0d idle done got %b exp 0", tag, c, s_done); end
            if (s_rd_en !== 1'b0) begin errors++; $display("FAIL %s c=%0d idle rd_en got %b exp 0", tag, c, s_rd_en); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_start = 1'b0;
        b_start = 1'b0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (s_busy !== 1'b0 || s_done !== 1'b0 || s_rd_en !== 1'b0 || s_wr_en !== 1'b0) begin
            errors++; $display("FAIL reset strobes got busy=%b done=%b rd=%b wr=%b exp 0", s_busy, s_done, s_rd_en, s_wr_en);
        end
        if ({s_rd_addr_0, s_rd_addr_1, s_rd_addr_2, s_rom_addr, s_wr_addr_0, s_wr_addr_1} !== 17'd0) begin
            errors++; $display("FAIL reset addresses got %h exp 0", {s_rd_addr_0, s_rd_addr_1, s_rd_addr_2, s_rom_addr, s_wr_addr_0, s_wr_addr_1});
        end
        if (s_stage !== 3'd0 || s_rd_bank !== 1'b0) begin errors++; $display("FAIL reset stage/bank got %0d/%b exp 0/0", s_stage, s_rd_bank); end
        if (s_res_bank !== 1'b1) begin errors++; $display("FAIL reset res_bank small got %b exp 1", s_res_bank); end
        if (b_res_bank !== 1'b0) begin errors++; $display("FAIL reset res_bank big got %b exp 0", b_res_bank); end
        if (b_busy !== 1'b0 || b_wr_en !== 1'b0) begin errors++; $display("FAIL reset big busy/wr got %b/%b exp 0/0", b_busy, b_wr_en); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stage_sequence();
        run_small("sequence", -1, 1'b0);
    endtask

    task automatic test_start_mid_run();
        run_small("start_mid_run", int'($urandom_range(0, 20)), 1'b0);
    endtask

    task automatic test_start_at_done();
        run_small("start_at_done", -1, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (7 + $urandom_range(0, 5)) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (s_busy !== 1'b0 || s_done !== 1'b0 || s_rd_en !== 1'b0 || s_wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_mid strobes got busy=%b done=%b rd=%b wr=%b exp 0", s_busy, s_done, s_rd_en, s_wr_en);
        end
        if ({s_rd_addr_0, s_rd_addr_1, s_rd_addr_2, s_rom_addr, s_wr_addr_0, s_wr_addr_1} !== 17'd0) begin
            errors++; $display("FAIL reset_mid addresses got %h exp 0", {s_rd_addr_0, s_rd_addr_1, s_rd_addr_2, s_rom_addr, s_wr_addr_0, s_wr_addr_1});
        end
        if (s_stage !== 3'd0 || s_rd_bank !== 1'b0) begin errors++; $display("FAIL reset_mid stage/bank got %0d/%b exp 0/0", s_stage, s_rd_bank); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            checks++;
            if (s_done !== 1'b0 || s_wr_en !== 1'b0 || s_busy !== 1'b0) begin
                errors++; $display("FAIL reset_mid after c=%0d done=%b wr=%b busy=%b exp 0", c, s_done, s_wr_en, s_busy);
            end
        end
        run_small("restart", -1, 1'b0);
    endtask

    task automatic test_big_run();
        int reads [8];
        int wcnt [8][256];
        int writes, done_cycle, st, idx, ws, wb, bad;
        for (int s = 0; s < 8; s++) begin
            reads[s] = 0;
            for (int a = 0; a < 256; a++) wcnt[s][a] = 0;
        end
        writes = 0;
        done_cycle = -1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 0; c < 8 * 131 + 20; c++) begin
            if (c > 0) @(negedge clk);
            if (b_rd_en === 1'b1) begin
                st  = int'(b_stage) & 7;
                idx = reads[st];
                checks++;
                if (b_rd_addr_0 !== 8'(model(8, st, idx, 0)) || b_rd_addr_1 !== 8'(model(8, st, idx, 1)) ||
                    b_rd_addr_2 !== 8'(model(8, st, idx, 2)) || b_rom_addr !== 7'(model(8, st, idx, 3)) ||
                    b_rd_bank !== 1'(st % 2)) begin
                    errors++;
                    $display("FAIL big_read s=%0d b=%0d got %0d,%0d,%0d,%0d bank %b exp %0d,%0d,%0d,%0d bank %0d", st, idx,
                             b_rd_addr_0, b_rd_addr_1, b_rd_addr_2, b_rom_addr, b_rd_bank,
                             model(8, st, idx, 0), model(8, st, idx, 1), model(8, st, idx, 2), model(8, st, idx, 3), st % 2);
                end
                reads[st]++;
            end
            if (b_wr_en === 1'b1) begin
                ws = (writes / 128) & 7;
                wb = writes % 128;
                checks++;
                if (b_wr_addr_0 !== 8'(model(8, ws, wb, 0)) || b_wr_addr_1 !== 8'(model(8, ws, wb, 1))) begin
                    errors++;
                    $display("FAIL big_write n=%0d got %0d,%0d exp %0d,%0d", writes, b_wr_addr_0, b_wr_addr_1,
                             model(8, ws, wb, 0), model(8, ws, wb, 1));
                end
                wcnt[ws][b_wr_addr_0]++;
                wcnt[ws][b_wr_addr_1]++;
                writes++;
            end
            if (b_done === 1'b1) begin
                done_cycle = c;
                break;
            end
        end
        checks += 2;
        if (done_cycle != 8 * 131) begin errors++; $display("FAIL big_done cycle got %0d exp %0d", done_cycle, 8 * 131); end
        if (writes != 1024) begin errors++; $display("FAIL big_writes got %0d exp 1024", writes); end
        for (int s = 0; s < 8; s++) begin
            bad = 0;
            for (int a = 0; a < 256; a++) if (wcnt[s][a] != 1) bad++;
            checks += 2;
            if (reads[s] != 128) begin errors++; $display("FAIL big_reads stage %0d got %0d exp 128", s, reads[s]); end
            if (bad != 0) begin errors++; $display("FAIL big_coverage stage %0d addresses not written once got %0d exp 0", s, bad); end
        end
        @(negedge clk);
        checks++;
        if (b_busy !== 1'b0) begin errors++; $display("FAIL big_idle busy got %b exp 0", b_busy); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stage_sequence();
        test_start_mid_run();
        test_start_at_done();
        test_reset_mid_run();
        test_big_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
